// File: rtl/l2shift_pkg.sv
// Shared constants and types for jump-target formation.
package l2shift_pkg;

  localparam int unsigned IDX_W   = 26;
  localparam int unsigned JSH     = 2;
  localparam int unsigned PC_HI_W = 4;

  typedef logic [IDX_W-1:0]                 jidx_t;
  typedef logic [IDX_W+JSH-1:0]             joff_t;
  typedef logic [PC_HI_W+IDX_W+JSH-1:0]     jaddr_t;

endpackage

// File: rtl/l2shift_comb.sv
// Stateless shift-and-pad: the instruction index becomes a word-aligned byte offset.
module l2shift_comb
  import l2shift_pkg::*;
#(
  parameter int unsigned IN_W = IDX_W,
  parameter int unsigned SH   = JSH
) (
  input  logic [IN_W-1:0]    in_i,
  output logic [IN_W+SH-1:0] out_o
);

  assign out_o = {in_i, {SH{1'b0}}};

endmodule

// File: rtl/l2shift.sv
// Jump-target unit: combinational shifted offset plus a registered {pc_hi, offset} target.
// Build option L2SHIFT_HOLD_EN: when defined, jt_q holds its last capture while idle.
module l2shift
  import l2shift_pkg::*;
#(
  parameter int unsigned IN_W    = l2shift_pkg::IDX_W,
  parameter int unsigned SH      = l2shift_pkg::JSH,
  parameter int unsigned PC_HI_W = l2shift_pkg::PC_HI_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IN_W-1:0]            in,
  output logic [IN_W+SH-1:0]         out,
  input  logic [PC_HI_W-1:0]         pc_hi,
  input  logic                       in_valid,
  output logic [PC_HI_W+IN_W+SH-1:0] jt_q,
  output logic                       jt_valid
);

  localparam int unsigned OUT_W = IN_W + SH;
  localparam int unsigned JT_W  = PC_HI_W + OUT_W;

  logic [OUT_W-1:0] off;
  logic [JT_W-1:0]  jt_d;
  logic             jt_valid_d;

  l2shift_comb #(
    .IN_W (IN_W),
    .SH   (SH)
  ) u_comb (
    .in_i  (in),
    .out_o (off)
  );

  assign out = off;

  // Idle behaviour of the target register depends on the hold option.
  always_comb begin
    jt_valid_d = in_valid;
`ifdef L2SHIFT_HOLD_EN
    jt_d       = jt_q;
`else
    jt_d       = '0;
`endif
    if (in_valid) begin
      jt_d = {pc_hi, off};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jt_q     <= '0;
      jt_valid <= 1'b0;
    end else begin
      jt_q     <= jt_d;
      jt_valid <= jt_valid_d;
    end
  end

endmodule

// File: tb/tb_l2shift.sv
// Directed self-checking bench for l2shift; honours L2SHIFT_HOLD_EN for idle expectations.
module tb_l2shift;

  logic        clk;
  logic        rst_n;
  logic [25:0] in;
  logic [27:0] out;
  logic [3:0]  pc_hi;
  logic        in_valid;
  logic [31:0] jt_q;
  logic        jt_valid;

  int errors = 0;
  int checks = 0;

  l2shift dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .out      (out),
    .pc_hi    (pc_hi),
    .in_valid (in_valid),
    .jt_q     (jt_q),
    .jt_valid (jt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] idle_exp;

    // Reset with capture requested and all-ones index
    rst_n = 1'b0; in_valid = 1'b1; in = 26'h3FFFFFF; pc_hi = 4'hF;
    edge1();
    edge1();
    chk("rst_jt_q", jt_q, 32'h0);
    chk("rst_jt_valid", 32'(jt_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0FFFFFFC);

    // Combinational path
    rst_n = 1'b1; in_valid = 1'b0;
    in = 26'h200D751; #1;
    chk("comb_a", 32'(out), 32'h08035D44);
    in = 26'h3FFFFFF; #1;
    chk("comb_ones", 32'(out), 32'h0FFFFFFC);
    in = 26'h0; #1;
    chk("comb_zero", 32'(out), 32'h0);

    // Single capture
    pc_hi = 4'hA; in = 26'h200D751; in_valid = 1'b1;
    edge1();
    in_valid = 1'b0; in = 26'h0;
    chk("cap_jt_q", jt_q, 32'hA8035D44);
    chk("cap_jt_valid", 32'(jt_valid), 32'h1);
    #2;
    in = 26'h1234567; #1;
    chk("cap_between_edges", jt_q, 32'hA8035D44);
    chk("comb_between_edges", 32'(out), 32'h048D159C);
    in = 26'h0;

    // Idle after capture
`ifdef L2SHIFT_HOLD_EN
    idle_exp = 32'hA8035D44;
`else
    idle_exp = 32'h0;
`endif
    edge1();
    chk("idle_jt_valid", 32'(jt_valid), 32'h0);
    chk("idle_jt_q", jt_q, idle_exp);

    // Back-to-back captures
    pc_hi = 4'h0; in = 26'h3FFFFFF; in_valid = 1'b1;
    edge1();
    pc_hi = 4'hF; in = 26'h0;
    chk("b2b_first_q", jt_q, 32'h0FFFFFFC);
    chk("b2b_first_v", 32'(jt_valid), 32'h1);
    edge1();
    in_valid = 1'b0;
    chk("b2b_second_q", jt_q, 32'hF0000000);
    chk("b2b_second_v", 32'(jt_valid), 32'h1);
`ifdef L2SHIFT_HOLD_EN
    idle_exp = 32'hF0000000;
`else
    idle_exp = 32'h0;
`endif
    edge1();
    chk("b2b_idle_v", 32'(jt_valid), 32'h0);
    chk("b2b_idle_q", jt_q, idle_exp);

    // Reset mid-stream beats a pending capture
    pc_hi = 4'h5; in = 26'h0123456; in_valid = 1'b1;
    edge1();
    chk("pre_rst_q", jt_q, 32'h5048D158);
    rst_n = 1'b0; pc_hi = 4'h3; in = 26'h2AAAAAA;
    edge1();
    chk("mid_rst_q", jt_q, 32'h0);
    chk("mid_rst_v", 32'(jt_valid), 32'h0);
    chk("mid_rst_out", 32'(out), 32'h0AAAAAA8);

    // Recovery after reset
    rst_n = 1'b1; pc_hi = 4'h7; in = 26'h0000001;
    edge1();
    in_valid = 1'b0;
    chk("recover_q", jt_q, 32'h70000004);
    chk("recover_v", 32'(jt_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
